// File: rtl/booth_mult_radix4_if.sv
// booth_mult_radix4_if: operand, handshake and result signals of the radix-4 Booth multiplier.
// The master drives operands and i_start; the slave (the multiplier) drives the results.
interface booth_mult_radix4_if #(
    parameter int unsigned L_WORD = 8
);
    logic [L_WORD-1:0]   i_word1;
    logic [L_WORD-1:0]   i_word2;
    logic                i_signed;
    logic                i_start;
    logic                o_ready;
    logic                o_valid;
    logic [2*L_WORD-1:0] o_product;
    logic                o_err;

    modport master (
        output i_word1, i_word2, i_signed, i_start,
        input  o_ready, o_valid, o_product, o_err
    );

    modport slave (
        input  i_word1, i_word2, i_signed, i_start,
        output o_ready, o_valid, o_product, o_err
    );
endinterface

// File: rtl/booth_mult_radix4.sv
// booth_mult_radix4: sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Operands are sign- or zero-extended to L_WORD+2 bits so one datapath serves both modes.
// Optional feature: define BOOTH_MULT_R4_ZSKIP_EN to finish early once every remaining
// Booth digit is zero (data-dependent latency, identical results and handshake).
module booth_mult_radix4 #(
    parameter int unsigned L_WORD = 8
) (
    input logic                i_clk,
    input logic                i_rst,
    booth_mult_radix4_if.slave bus
);
    localparam int unsigned W  = L_WORD + 2;
    localparam int unsigned AW = W + 2;
    localparam int unsigned N  = W / 2;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       a_q, a_d;
    logic [W-1:0]        q_q, q_d;
    logic                qm1_q, qm1_d;
    logic [W-1:0]        m_q, m_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*L_WORD-1:0] prod_q, prod_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [AW-1:0]       m_ext, digit, a_sum;
    logic [AW+W:0]       step;
    logic [W-1:0]        ext1, ext2;

    // Recode the current triplet, add the digit to A and shift {A,Q,q_m1} right by two.
    always_comb begin
        m_ext = {{2{m_q[W-1]}}, m_q};
        digit = '0;
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: digit = m_ext;
            3'b011:         digit = m_ext << 1;
            3'b100:         digit = -(m_ext << 1);
            3'b101, 3'b110: digit = -m_ext;
            default:        digit = '0;
        endcase
        a_sum = a_q + digit;
        step  = $signed({a_sum, q_q, qm1_q}) >>> 2;
    end

    // Extend incoming operands according to the requested mode.
    always_comb begin
        if (bus.i_signed) begin
            ext1 = {{2{bus.i_word1[L_WORD-1]}}, bus.i_word1};
            ext2 = {{2{bus.i_word2[L_WORD-1]}}, bus.i_word2};
        end else begin
            ext1 = {2'b00, bus.i_word1};
            ext2 = {2'b00, bus.i_word2};
        end
    end

`ifdef BOOTH_MULT_R4_ZSKIP_EN
    logic                zs_hit;
    logic [CW-1:0]       zs_rem;
    logic [AW+W-1:0]     zs_out;

    // Uniform {Q,q_m1} means every remaining digit is zero: apply all remaining shifts at once.
    always_comb begin
        zs_hit = (&{q_q, qm1_q}) | ~(|{q_q, qm1_q});
        zs_rem = CW'(N) - cnt_q;
        zs_out = $signed({a_q, q_q}) >>> {zs_rem, 1'b0};
    end
`endif

    // Next-state logic: accept, iterate, then publish the result for one cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    a_d     = '0;
                    q_d     = ext2;
                    qm1_d   = 1'b0;
                    m_d     = ext1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // A start here is refused; the operation in flight is untouched.
                err_d = bus.i_start;
`ifdef BOOTH_MULT_R4_ZSKIP_EN
                if (zs_hit) begin
                    a_d     = zs_out[AW+W-1:W];
                    q_d     = zs_out[W-1:0];
                    qm1_d   = 1'b0;
                    state_d = StDone;
                end else
`endif
                begin
                    a_d   = step[AW+W:W+1];
                    q_d   = step[W:1];
                    qm1_d = step[0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                valid_d = 1'b1;
                prod_d  = {a_q[L_WORD-3:0], q_q};
                if (bus.i_start) begin
                    a_d     = '0;
                    q_d     = ext2;
                    qm1_d   = 1'b0;
                    m_d     = ext1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation without producing a result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready   = (state_q != StCalc);
    assign bus.o_valid   = valid_q;
    assign bus.o_product = prod_q;
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_booth_mult_radix4.sv
// tb_booth_mult_radix4: directed vectors for booth_mult_radix4 (L_WORD=8) with a
// latency-timeline reference model compared against the outputs every cycle.
// Build with BOOTH_MULT_R4_ZSKIP_EN defined to exercise the early-termination variant.
module tb_booth_mult_radix4;
    localparam int unsigned L = 8;
    localparam int N = L / 2 + 1;

    logic clk = 1'b0;
    logic rst;

    booth_mult_radix4_if #(.L_WORD(L)) bus ();

    booth_mult_radix4 #(.L_WORD(L)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int last_lat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [2*L-1:0] ref_mul(input logic [L-1:0] a, input logic [L-1:0] b,
                                              input logic s);
        longint pa, pb, p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*L-1:0];
    endfunction

    // Reference model: an accepted start yields its product N+1 edges later and the block
    // is busy for the N edges after acceptance.
    int             edge_n   = 0;
    int             due      = -1;
    int             ready_at = 0;
    logic           exp_valid, exp_err;
    logic [2*L-1:0] exp_prod, pending;
    logic [2*L-1:0] expq[$];
`ifdef BOOTH_MULT_R4_ZSKIP_EN
    logic           ready_s = 1'b1;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_at  <= 0;
            due       <= -1;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_prod  <= '0;
            expq.delete();
        end else begin
            edge_n    <= edge_n + 1;
            exp_valid <= (edge_n + 1 == due);
            if (edge_n + 1 == due) exp_prod <= pending;
            exp_err   <= 1'b0;
            if (bus.i_start) begin
`ifdef BOOTH_MULT_R4_ZSKIP_EN
                if (ready_s) begin
`else
                if (edge_n >= ready_at) begin
`endif
                    pending  <= ref_mul(bus.i_word1, bus.i_word2, bus.i_signed);
                    due      <= edge_n + 1 + N + 1;
                    ready_at <= edge_n + 1 + N;
                    expq.push_back(ref_mul(bus.i_word1, bus.i_word2, bus.i_signed));
                end else begin
                    exp_err <= 1'b1;
                end
            end
        end
    end

    // Compare process, sampling on the falling edge.
    always @(negedge clk) begin
`ifdef BOOTH_MULT_R4_ZSKIP_EN
        ready_s <= bus.o_ready;
`endif
        if (!rst) begin
`ifndef BOOTH_MULT_R4_ZSKIP_EN
            check("model_ready", bus.o_ready, edge_n >= ready_at);
            check("model_valid", bus.o_valid, exp_valid);
            check("model_product", bus.o_product, exp_prod);
`endif
            check("model_err", bus.o_err, exp_err);
            if (bus.o_valid) begin
                if (expq.size() == 0) check("model_spurious_valid", bus.o_valid, 1'b0);
                else check("model_result", bus.o_product, expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Wait (bounded) for o_valid; lat is edges since e0, or -1 on timeout.
    task automatic wait_valid(input int e0, output int lat, output int errs);
        lat  = -1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_err) errs++;
            if (bus.o_valid) begin
                lat = edge_n - e0;
                break;
            end
        end
    endtask

    task automatic check_lat(input string name, input int lat);
`ifdef BOOTH_MULT_R4_ZSKIP_EN
        check(name, 64'(lat >= 2 && lat <= N + 1), 64'd1);
`else
        check(name, 64'(lat), 64'(N + 1));
`endif
    endtask

    task automatic run_op(input string name, input logic [L-1:0] a, input logic [L-1:0] b,
                          input logic s, input logic [2*L-1:0] expp);
        int e0, lat, errs;
        bus.i_word1  = a;
        bus.i_word2  = b;
        bus.i_signed = s;
        bus.i_start  = 1'b1;
        tick();
        e0 = edge_n;
        bus.i_start  = 1'b0;
        bus.i_word1  = L'($urandom);
        bus.i_word2  = L'($urandom);
        bus.i_signed = ~s;
        wait_valid(e0, lat, errs);
        check({name, "_product"}, bus.o_product, expp);
        check_lat({name, "_latency"}, lat);
        last_lat = lat;
    endtask

    initial begin
        int e0, e1, lat, errs, nvalid;
        bus.i_word1  = '0;
        bus.i_word2  = '0;
        bus.i_signed = 1'b0;
        bus.i_start  = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_ready", bus.o_ready, 1'b1);
        check("reset_valid", bus.o_valid, 1'b0);
        check("reset_product", bus.o_product, 16'h0000);
        check("reset_err", bus.o_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run_op("s_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080);
        run_op("u128x2", 8'h80, 8'h02, 1'b0, 16'h0100);
        run_op("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op("u0xAB", 8'h00, 8'hAB, 1'b0, 16'h0000);

        // Back-to-back: i_start held from the first accept through DONE.
        bus.i_word1  = 8'd7;
        bus.i_word2  = 8'd9;
        bus.i_signed = 1'b0;
        bus.i_start  = 1'b1;
        tick();
        e0 = edge_n;
        bus.i_word1 = 8'd12;
        bus.i_word2 = 8'd12;
        wait_valid(e0, lat, errs);
        check("b2b_first_product", bus.o_product, 16'd63);
        check_lat("b2b_first_latency", lat);
        bus.i_start = 1'b0;
        e1 = e0 + lat;
        wait_valid(e1, lat, errs);
        check("b2b_second_product", bus.o_product, 16'd144);
        check_lat("b2b_second_latency", lat);

        // Start while busy: one err pulse, result unaffected, no extra valid.
        bus.i_word1 = 8'd15;
        bus.i_word2 = 8'd15;
        bus.i_start = 1'b1;
        tick();
        e0 = edge_n;
        bus.i_start = 1'b0;
        tick();
        tick();
        bus.i_word1 = 8'd3;
        bus.i_word2 = 8'd3;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_valid(e0, lat, errs);
        check("busy_err_pulses", 64'(errs), 64'd1);
        check("busy_product", bus.o_product, 16'd225);
        check_lat("busy_latency", lat);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_valid) nvalid++;
        end
        check("busy_no_extra_valid", 64'(nvalid), 64'd0);

        // Reset in the middle of CALC.
        bus.i_word1 = 8'd9;
        bus.i_word2 = 8'd9;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", bus.o_ready, 1'b1);
        check("midrst_product", bus.o_product, 16'h0000);
        check("midrst_valid", bus.o_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_valid) nvalid++;
        end
        check("midrst_no_valid", 64'(nvalid), 64'd0);
        run_op("after_rst_13x11", 8'd13, 8'd11, 1'b0, 16'd143);

        run_op("u100x1", 8'd100, 8'd1, 1'b0, 16'd100);
`ifdef BOOTH_MULT_R4_ZSKIP_EN
        check("zskip_early_finish", 64'(last_lat >= 2 && last_lat < 6), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
        $fatal(1);
    end
endmodule
